// File: rtl/itrx_aib_phy_pkg.sv
// Shared definitions for the AIB PHY transmit/receive blocks.
// Holds the TX mode encodings, the PRBS7 generator constants and a one-step
// PRBS7 helper so TX and RX checkers advance the sequence identically.
package itrx_aib_phy_pkg;

  localparam logic [1:0] TXM_NORM = 2'b00;
  localparam logic [1:0] TXM_PRBS = 2'b01;
  localparam logic [1:0] TXM_CLK  = 2'b10;
  localparam logic [1:0] TXM_ZERO = 2'b11;

  // x^7 + x^6 + 1: feedback is the XOR of the two oldest stages
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } txState_e;

  // Advance the LFSR by one bit; the newly generated bit lands in bit 0
  function automatic logic [6:0] prbs7Next(input logic [6:0] state);
    return {state[5:0], ^(state & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/itrx_aib_phy_redn_mux.sv
// Logical-to-physical lane steering around one failed lane.
// Ports:
//   ch_i        logical channel bits, one per channel
//   redn_en_i   steering enable
//   redn_idx_i  physical lane that is skipped (forced to 0)
//   lane_o      physical lane bits, NUM_CH+1 lanes (last one is the spare)
// An index beyond the spare lane behaves as if steering were disabled.
module itrx_aib_phy_redn_mux #(
  parameter int NUM_CH = 20,
  parameter int IDXW   = $clog2(NUM_CH + 1)
) (
  input  logic [NUM_CH-1:0] ch_i,
  input  logic              redn_en_i,
  input  logic [IDXW-1:0]   redn_idx_i,
  output logic [NUM_CH:0]   lane_o
);

  logic enEff;

  assign enEff = redn_en_i && (redn_idx_i <= IDXW'(NUM_CH));

  // Lanes below the failed index pass straight, the failed lane is blanked,
  // lanes above it take the channel one below.
  for (genvar q = 0; q <= NUM_CH; q++) begin : gLane
    if (q == 0) begin : gFirst
      assign lane_o[q] = (enEff && (redn_idx_i == '0)) ? 1'b0 : ch_i[0];
    end else if (q < NUM_CH) begin : gMid
      assign lane_o[q] = !enEff                        ? ch_i[q]   :
                         (redn_idx_i == IDXW'(q))      ? 1'b0      :
                         (redn_idx_i <  IDXW'(q))      ? ch_i[q-1] :
                                                         ch_i[q];
    end else begin : gSpare
      assign lane_o[q] = (enEff && (redn_idx_i < IDXW'(q))) ? ch_i[q-1] : 1'b0;
    end
  end

endmodule

// File: rtl/itrx_aib_phy_tx_gearbox.sv
// Multi-channel AIB transmit gearbox (ilaunch_clk domain).
// Serialises 2*GEAR-bit words per channel at 2 bits/cycle (DDR) or
// 1 bit/cycle (SDR), with PRBS7, clock-pattern and force-zero test modes and
// spare-lane steering.
// Ports:
//   ilaunch_clk, tx_irstb      clock, async active-low reset
//   tx_mode                    00 normal, 01 PRBS7, 10 clock, 11 zero
//   iddr_enable                1 = DDR, 0 = SDR
//   tx_data/tx_valid/tx_ready  word handshake, channel c at [c*2*GEAR +: 2*GEAR]
//   redn_en, redn_idx          failed physical lane steering
//   idat0, idat1               registered launch bits per physical lane
//   tx_underrun                sticky: a word slot found the hold register empty
module itrx_aib_phy_tx_gearbox
  import itrx_aib_phy_pkg::*;
#(
  parameter int NUM_CH = 20,
  parameter int GEAR   = 4,
  parameter int IDXW   = $clog2(NUM_CH + 1)
) (
  input  logic                     ilaunch_clk,
  input  logic                     tx_irstb,
  input  logic [1:0]               tx_mode,
  input  logic                     iddr_enable,
  input  logic [NUM_CH*2*GEAR-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic                     redn_en,
  input  logic [IDXW-1:0]          redn_idx,
  output logic [NUM_CH:0]          idat0,
  output logic [NUM_CH:0]          idat1,
  output logic                     tx_underrun
);

  localparam int W  = 2 * GEAR;
  localparam int PW = $clog2(W);
  localparam logic [PW-1:0] LAST_DDR = PW'(GEAR - 1);
  localparam logic [PW-1:0] LAST_SDR = PW'(W - 1);

  txState_e                 state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [NUM_CH-1:0][W-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0][W-1:0] shift_q, shift_d;
  logic                     holdFull_q, holdFull_d;
  logic [PW-1:0]            phase_q, phase_d;
  logic [6:0]               lfsr_q, lfsr_d;
  logic                     clkPh_q, clkPh_d;
  logic                     underrun_q, underrun_d;
  logic [NUM_CH:0]          idat0_q, idat0_d, idat1_q, idat1_d;

  logic                     modeChange, lastBeat, holdMove, accept;
  logic [NUM_CH-1:0]        chBit0, chBit1;
  logic [NUM_CH:0]          lane0, lane1;
  logic [6:0]               lfsrStep1, lfsrStep2;

  // Handshake: the hold register counts as free when it is empty or when it
  // is being emptied into the shift register on this very edge, so words
  // stream back to back. Any pending mode change blocks acceptance.
  always_comb begin
    modeChange = (mode_q != tx_mode);
    lastBeat   = (state_q == ST_RUN) &&
                 (phase_q == (iddr_enable ? LAST_DDR : LAST_SDR));
    holdMove   = holdFull_q && ((state_q == ST_IDLE) || lastBeat);
    tx_ready   = tx_irstb && !modeChange && (tx_mode == TXM_NORM) &&
                 (!holdFull_q || holdMove);
    accept     = tx_valid && tx_ready;
  end

  // Per-channel bits for the next launch, before steering. In SDR both
  // launch inputs carry the same bit.
  always_comb begin
    lfsrStep1 = prbs7Next(lfsr_q);
    lfsrStep2 = prbs7Next(lfsrStep1);
    chBit0    = '0;
    chBit1    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (mode_q)
        TXM_NORM: begin
          chBit0[c] = shift_q[c][0];
          chBit1[c] = iddr_enable ? shift_q[c][1] : shift_q[c][0];
        end
        TXM_PRBS: begin
          chBit0[c] = lfsrStep1[0];
          chBit1[c] = iddr_enable ? lfsrStep2[0] : lfsrStep1[0];
        end
        default: ;
      endcase
    end
  end

  itrx_aib_phy_redn_mux #(.NUM_CH(NUM_CH), .IDXW(IDXW)) u_redn0 (
    .ch_i       (chBit0),
    .redn_en_i  (redn_en),
    .redn_idx_i (redn_idx),
    .lane_o     (lane0)
  );

  itrx_aib_phy_redn_mux #(.NUM_CH(NUM_CH), .IDXW(IDXW)) u_redn1 (
    .ch_i       (chBit1),
    .redn_en_i  (redn_en),
    .redn_idx_i (redn_idx),
    .lane_o     (lane1)
  );

  // Next-state: a mode change wipes everything and launches zeros; otherwise
  // the word slot logic runs and the output register follows the current mode.
  always_comb begin
    state_d    = state_q;
    mode_d     = tx_mode;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    shift_d    = shift_q;
    phase_d    = phase_q;
    lfsr_d     = lfsr_q;
    clkPh_d    = clkPh_q;
    underrun_d = underrun_q;
    idat0_d    = '0;
    idat1_d    = '0;
    if (modeChange) begin
      state_d    = ST_IDLE;
      hold_d     = '0;
      holdFull_d = 1'b0;
      shift_d    = '0;
      phase_d    = '0;
      lfsr_d     = PRBS7_SEED;
      clkPh_d    = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (holdMove) begin
        shift_d    = hold_q;
        phase_d    = '0;
        state_d    = ST_RUN;
        holdFull_d = 1'b0;
      end else if (lastBeat) begin
        // Slot boundary with nothing waiting: launch a zero word
        shift_d    = '0;
        phase_d    = '0;
        underrun_d = 1'b1;
      end else if (state_q == ST_RUN) begin
        for (int c = 0; c < NUM_CH; c++) begin
          shift_d[c] = iddr_enable ? (shift_q[c] >> 2) : (shift_q[c] >> 1);
        end
        phase_d = phase_q + 1'b1;
      end
      if (accept) begin
        hold_d     = tx_data;
        holdFull_d = 1'b1;
      end
      case (mode_q)
        TXM_NORM: begin
          idat0_d = lane0;
          idat1_d = lane1;
        end
        TXM_PRBS: begin
          idat0_d = lane0;
          idat1_d = lane1;
          lfsr_d  = iddr_enable ? lfsrStep2 : lfsrStep1;
        end
        TXM_CLK: begin
          // Clock pattern drives every physical lane, spare included
          if (iddr_enable) begin
            idat0_d = '1;
          end else begin
            idat0_d = {(NUM_CH + 1){~clkPh_q}};
            idat1_d = {(NUM_CH + 1){~clkPh_q}};
            clkPh_d = ~clkPh_q;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge ilaunch_clk or negedge tx_irstb) begin
    if (!tx_irstb) begin
      state_q    <= ST_IDLE;
      mode_q     <= TXM_NORM;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      shift_q    <= '0;
      phase_q    <= '0;
      lfsr_q     <= PRBS7_SEED;
      clkPh_q    <= 1'b0;
      underrun_q <= 1'b0;
      idat0_q    <= '0;
      idat1_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      shift_q    <= shift_d;
      phase_q    <= phase_d;
      lfsr_q     <= lfsr_d;
      clkPh_q    <= clkPh_d;
      underrun_q <= underrun_d;
      idat0_q    <= idat0_d;
      idat1_q    <= idat1_d;
    end
  end

  assign idat0       = idat0_q;
  assign idat1       = idat1_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_itrx_aib_phy_tx_gearbox.sv
// Scoreboard bench for the AIB TX gearbox: a word/slot level reference model
// predicts each cycle's launch bits, underrun flag and tx_ready; a separate
// monitor compares them against the DUT on the falling edge.
`timescale 1ns/1ps
module tb_itrx_aib_phy_tx_gearbox;

   localparam int NUM_CH = 2;
   localparam int GEAR   = 2;
   localparam int IDXW   = $clog2(NUM_CH + 1);
   localparam int W      = 2 * GEAR;
   localparam int DW     = NUM_CH * W;
   localparam int NL     = NUM_CH + 1;
   localparam logic [1:0] M_NORM = 2'b00;
   localparam logic [1:0] M_PRBS = 2'b01;
   localparam logic [1:0] M_CLK  = 2'b10;
   localparam logic [1:0] M_ZERO = 2'b11;

   logic          ilaunch_clk = 1'b0;
   logic          tx_irstb;
   logic [1:0]    tx_mode;
   logic          iddr_enable;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          redn_en;
   logic [IDXW-1:0] redn_idx;
   logic [NL-1:0] idat0;
   logic [NL-1:0] idat1;
   logic          tx_underrun;

   itrx_aib_phy_tx_gearbox #(.NUM_CH(NUM_CH), .GEAR(GEAR), .IDXW(IDXW)) dut (
      .ilaunch_clk (ilaunch_clk),
      .tx_irstb    (tx_irstb),
      .tx_mode     (tx_mode),
      .iddr_enable (iddr_enable),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .redn_en     (redn_en),
      .redn_idx    (redn_idx),
      .idat0       (idat0),
      .idat1       (idat1),
      .tx_underrun (tx_underrun)
   );

   always #5 ilaunch_clk = ~ilaunch_clk;

   typedef struct packed {
      logic [NL-1:0] d0;
      logic [NL-1:0] d1;
   } beat_t;

   typedef struct packed {
      int            edgeNo;
      logic [NL-1:0] d0;
      logic [NL-1:0] d1;
      logic          und;
   } outExp_t;

   typedef struct packed {
      int   edgeNo;
      logic rdy;
   } rdyExp_t;

   int      edgeCnt = 0;
   int      nCompared = 0;
   int      nMismatched = 0;
   outExp_t outQ[$];
   rdyExp_t readyQ[$];

   // Reference model state
   logic [1:0]    mMode;
   bit            mStarted, mHoldValid, mUnderrun, mClkPh;
   logic [DW-1:0] mHold;
   int            mNextLoad, mPrbsIdx;
   beat_t         beatQ[$];
   bit            prbsSeq[127];

   // Rising-edge counter shared by stimulus and monitor to tag expectations
   always @(posedge ilaunch_clk) edgeCnt <= edgeCnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Place logical channels onto physical lanes by inserting a blank at the
   // failed position (or appending the idle spare).
   function automatic logic [NL-1:0] steer(input logic [NUM_CH-1:0] ch);
      bit            lanes[$];
      logic [NL-1:0] r;
      for (int c = 0; c < NUM_CH; c++) lanes.push_back(ch[c]);
      if (redn_en && (int'(redn_idx) <= NUM_CH)) lanes.insert(int'(redn_idx), 1'b0);
      else lanes.push_back(1'b0);
      for (int q = 0; q < NL; q++) r[q] = lanes[q];
      return r;
   endfunction

   task automatic resetModel();
      mMode      = M_NORM;
      mStarted   = 0;
      mHoldValid = 0;
      mUnderrun  = 0;
      mClkPh     = 0;
      mHold      = '0;
      mNextLoad  = 0;
      mPrbsIdx   = 0;
      beatQ.delete();
   endtask

   // Drive one cycle of inputs, predict the DUT response for the coming edge
   // and queue it for the monitor, then advance one clock.
   task automatic applyStimulus(input logic [1:0] mode, input logic valid, input logic [DW-1:0] data);
      int            e, slotBeats;
      bit            rdyExp, loadNow;
      beat_t         outB, b;
      logic [DW-1:0] word;
      logic [W-1:0]  chunk;
      logic [NUM_CH-1:0] c0, c1;
      outExp_t       oe;
      rdyExp_t       re;
      tx_mode   = mode;
      tx_valid  = valid;
      tx_data   = data;
      e         = edgeCnt + 1;
      slotBeats = iddr_enable ? GEAR : 2 * GEAR;
      outB      = '0;
      rdyExp    = 0;
      if (mode != mMode) begin
         resetModel();
         mMode = mode;
      end else begin
         loadNow = mStarted && (e == mNextLoad);
         rdyExp  = (mMode == M_NORM) && (!mHoldValid || loadNow);
         case (mMode)
            M_NORM: if (beatQ.size() > 0) outB = beatQ.pop_front();
            M_PRBS: begin
               c0 = {NUM_CH{prbsSeq[mPrbsIdx]}};
               c1 = iddr_enable ? {NUM_CH{prbsSeq[(mPrbsIdx + 1) % 127]}} : c0;
               outB.d0 = steer(c0);
               outB.d1 = steer(c1);
               mPrbsIdx = (mPrbsIdx + (iddr_enable ? 2 : 1)) % 127;
            end
            M_CLK: begin
               if (iddr_enable) outB.d0 = '1;
               else begin
                  outB.d0 = mClkPh ? '0 : '1;
                  outB.d1 = outB.d0;
                  mClkPh  = !mClkPh;
               end
            end
            default: ;
         endcase
         if (loadNow) begin
            word = mHoldValid ? mHold : '0;
            if (!mHoldValid) mUnderrun = 1;
            for (int k = 0; k < slotBeats; k++) begin
               for (int c = 0; c < NUM_CH; c++) begin
                  chunk = word[c*W +: W];
                  c0[c] = iddr_enable ? chunk[2*k]   : chunk[k];
                  c1[c] = iddr_enable ? chunk[2*k+1] : chunk[k];
               end
               b.d0 = steer(c0);
               b.d1 = steer(c1);
               beatQ.push_back(b);
            end
            mHoldValid = 0;
            mNextLoad  = mNextLoad + slotBeats;
         end
         if (valid && rdyExp) begin
            mHold      = data;
            mHoldValid = 1;
            if (!mStarted) begin
               mStarted  = 1;
               mNextLoad = e + 1;
            end
         end
      end
      re.edgeNo = e;
      re.rdy    = rdyExp;
      readyQ.push_back(re);
      oe.edgeNo = e;
      oe.d0     = outB.d0;
      oe.d1     = outB.d1;
      oe.und    = mUnderrun;
      outQ.push_back(oe);
      @(posedge ilaunch_clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge ilaunch_clk);
      #1;
      tx_irstb = 1'b0;
      tx_valid = 1'b0;
      tx_mode  = M_NORM;
      #1;
      checkOutput("rst_idat0", 32'(idat0), 32'd0);
      checkOutput("rst_idat1", 32'(idat1), 32'd0);
      checkOutput("rst_ready", 32'(tx_ready), 32'd0);
      checkOutput("rst_underrun", 32'(tx_underrun), 32'd0);
      repeat (2) @(negedge ilaunch_clk);
      tx_irstb = 1'b1;
      resetModel();
      @(posedge ilaunch_clk);
      #1;
   endtask

   task automatic randomStream(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         applyStimulus(M_NORM, ($urandom_range(0, 3) != 0), DW'($urandom));
      end
   endtask

   task automatic goZero();
      repeat (2) applyStimulus(M_ZERO, 1'b0, '0);
   endtask

   // Monitor: compares whatever expectation is due at this falling edge
   initial begin : monitor
      outExp_t o;
      rdyExp_t r;
      forever begin
         @(negedge ilaunch_clk);
         if (outQ.size() > 0 && outQ[0].edgeNo <= edgeCnt) begin
            o = outQ.pop_front();
            checkOutput($sformatf("idat0@%0d", o.edgeNo), 32'(idat0), 32'(o.d0));
            checkOutput($sformatf("idat1@%0d", o.edgeNo), 32'(idat1), 32'(o.d1));
            checkOutput($sformatf("underrun@%0d", o.edgeNo), 32'(tx_underrun), 32'(o.und));
         end
         if (readyQ.size() > 0 && readyQ[0].edgeNo <= edgeCnt + 1) begin
            r = readyQ.pop_front();
            checkOutput($sformatf("tx_ready@%0d", r.edgeNo), 32'(tx_ready), 32'(r.rdy));
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      nMismatched++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      bit ext[134];
      for (int i = 0; i < 7; i++) ext[i] = 1'b1;
      for (int i = 7; i < 134; i++) ext[i] = ext[i-6] ^ ext[i-7];
      for (int n = 0; n < 127; n++) prbsSeq[n] = ext[n+7];

      tx_irstb    = 1'b0;
      tx_mode     = M_NORM;
      iddr_enable = 1'b1;
      tx_data     = '0;
      tx_valid    = 1'b0;
      redn_en     = 1'b0;
      redn_idx    = '0;
      resetModel();
      doReset();

      // Idle after reset, then a constant word streamed back to back
      repeat (4) applyStimulus(M_NORM, 1'b0, '0);
      repeat (10) applyStimulus(M_NORM, 1'b1, 8'b0110_1001);
      // Starve the gearbox to provoke an underrun
      repeat (8) applyStimulus(M_NORM, 1'b0, '0);

      // Steering around lane 0, then the spare index and an out-of-range index
      goZero();
      redn_en = 1'b1; redn_idx = 2'd0;
      randomStream(40);
      goZero();
      redn_idx = 2'd2;
      randomStream(20);
      goZero();
      redn_idx = 2'd3;
      randomStream(20);
      goZero();
      redn_idx = 2'd1;
      randomStream(20);

      // SDR streaming
      goZero();
      iddr_enable = 1'b0;
      randomStream(40);

      // PRBS SDR over more than one full period, then PRBS DDR with steering
      goZero();
      redn_en = 1'b0;
      for (int i = 0; i < 140; i++) applyStimulus(M_PRBS, 1'($urandom), DW'($urandom));
      goZero();
      iddr_enable = 1'b1;
      redn_en  = 1'b1;
      redn_idx = IDXW'($urandom_range(0, 3));
      for (int i = 0; i < 70; i++) applyStimulus(M_PRBS, 1'($urandom), DW'($urandom));

      // Clock pattern in DDR and SDR
      repeat (6) applyStimulus(M_CLK, 1'b0, '0);
      goZero();
      iddr_enable = 1'b0;
      repeat (6) applyStimulus(M_CLK, 1'b0, '0);

      // Normal to clock pattern in the middle of a word, with a word still held
      goZero();
      iddr_enable = 1'b1;
      redn_en = 1'b0;
      applyStimulus(M_NORM, 1'b1, 8'hA5);
      applyStimulus(M_NORM, 1'b1, 8'h3C);
      applyStimulus(M_NORM, 1'b0, '0);
      repeat (5) applyStimulus(M_CLK, 1'b0, '0);
      repeat (6) applyStimulus(M_NORM, 1'b0, '0);

      // Reset in the middle of a stream drops the word in flight
      randomStream(7);
      doReset();
      repeat (6) applyStimulus(M_NORM, 1'b0, '0);
      redn_en  = 1'b1;
      redn_idx = IDXW'($urandom_range(0, 2));
      randomStream(20);
      repeat (4) applyStimulus(M_NORM, 1'b0, '0);

      for (int i = 0; i < 10 && (outQ.size() > 0 || readyQ.size() > 0); i++) @(negedge ilaunch_clk);
      if (outQ.size() > 0 || readyQ.size() > 0) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL drain: got %0d pending expectations, expected 0", outQ.size() + readyQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
